// File: rtl/pos_sweep_ctrl.sv
// pos_sweep_ctrl: steps a four-input combinational evaluator through all
// 16 input codes. It captures F for each code into a truth table and counts
// the zeros (maxterms).
//
// Optional feature macro: POS_SWEEP_COMPARE_EN
//   defined   -> mismatch register compares the final table with EXPECTED
//   undefined -> mismatch is tied to 0 and EXPECTED is unused
//
// state  | meaning
// IDLE   | waiting for start; abcd = 0, results held
// DRIVE  | abcd = index, evaluator settles for one full cycle
// SAMPLE | capture f_in into truth_table[index], count zeros, advance index
// DONE   | one-cycle done pulse; mismatch already valid; back to IDLE
module pos_sweep_ctrl #(
    parameter logic [15:0] EXPECTED = 16'h2EAC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [3:0]  abcd,
    input  logic        f_in,
    output logic [15:0] truth_table,
    output logic [4:0]  maxterm_count,
    output logic        mismatch
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  count_q, count_d;
    logic        mismatch_q, mismatch_d;
    logic        cmp_result;

`ifdef POS_SWEEP_COMPARE_EN
    assign cmp_result = (table_d != EXPECTED);
`else
    // Keeps EXPECTED referenced; the expression folds to a constant zero.
    assign cmp_result = 1'b0 & (^EXPECTED);
`endif

    // Next-state, index and capture logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        table_d    = table_q;
        count_d    = count_q;
        mismatch_d = mismatch_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d    = S_DRIVE;
                    idx_d      = 4'd0;
                    table_d    = 16'h0000;
                    count_d    = 5'd0;
                    mismatch_d = 1'b0;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = 4'd0;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = 4'd0;
                end else begin
                    table_d[idx_q] = f_in;
                    if (!f_in) begin
                        count_d = count_q + 5'd1;
                    end
                    // Terminal index is checked before incrementing, so the
                    // 4-bit index never wraps. The compare uses the table
                    // including this last capture, so mismatch is valid in DONE.
                    if (idx_q == 4'd15) begin
                        state_d    = S_DONE;
                        idx_d      = 4'd0;
                        mismatch_d = cmp_result;
                    end else begin
                        state_d = S_DRIVE;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            table_q    <= 16'h0000;
            count_q    <= 5'd0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            table_q    <= table_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
        end
    end

    // The index register drives the evaluator directly. It is zero outside a sweep.
    assign abcd          = idx_q;
    assign busy          = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done          = (state_q == S_DONE);
    assign truth_table   = table_q;
    assign maxterm_count = count_q;
    assign mismatch      = mismatch_q;

endmodule

// File: doc/pos_sweep_ctrl.md
# pos_sweep_ctrl

Sequencer that exhaustively drives the four-input product-of-sums evaluator through all 16 input combinations and captures its response as a truth table. The evaluator stays purely combinational; this block owns stimulus ordering, sampling, maxterm counting and, optionally, a golden-table compare. It sits between the lab's control/status interface and the evaluator instance, and is intended for self-check of the logic function on the board.

## Interface
- `EXPECTED`, default `16'h2EAC`: golden truth table; bit i = F for input index i (A=bit3 … D=bit0). Default has zeros at 0,1,4,6,8,12,14,15.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `start`  in  1  request a sweep; honoured only in IDLE.
- `abort`  in  1  terminate an active sweep.
- `busy`  out  1  high while sweeping (DRIVE/SAMPLE).
- `done`  out  1  one-cycle pulse when a sweep completes normally.
- `abcd`  out  4  evaluator inputs {A,B,C,D}, registered.
- `f_in`  in  1  evaluator output F (combinational function of `abcd`).
- `truth_table`  out  16  captured F values; bit i ↔ index i.
- `maxterm_count`  out  5  number of captured zeros (0..16).
- `mismatch`  out  1  `truth_table != EXPECTED` after completion (only with macro).

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE; one-hot or binary at implementer's choice.
- IDLE: `abcd`=0, `busy`=0. On `start`=1 and `abort`=0: clear `truth_table`, `maxterm_count`, `mismatch`; index←0; go DRIVE.
- DRIVE: `abcd` = index (already registered); evaluator settles for one full cycle; go SAMPLE.
- SAMPLE: `abcd` held; `truth_table[index]` ← `f_in`; if `f_in`=0, `maxterm_count` += 1. If index=15 go DONE, else index+1, go DRIVE.
- DONE: `done`=1, `busy`=0; evaluate `mismatch`; unconditionally go IDLE.
- Results (`truth_table`, `maxterm_count`, `mismatch`) hold from DONE until next accepted `start`.
- `abort`=1 in DRIVE or SAMPLE: next state IDLE, no capture that cycle, no `done`; partial table and count retained; `mismatch` stays 0.
- `abort` and `start` together in IDLE: abort wins, stay IDLE. `abort` in IDLE/DONE: no effect.
- `start` while busy or in DONE: ignored, not queued.
- Index counter is 4 bits; never wraps — terminal at 15 checked before increment.
- `maxterm_count` is 5 bits to represent 16 without overflow.

## Timing
- Reset (`rst_n`=0 at edge): state IDLE; `busy`=0, `done`=0, `abcd`=0, `truth_table`=0, `maxterm_count`=0, `mismatch`=0, index 0. Reset overrides everything including mid-sweep.
- Cycle 0: `start` sampled in IDLE. Cycle 1: DRIVE, `busy`=1, `abcd`=0.
- Index i: DRIVE at cycle 2i+1, SAMPLE at cycle 2i+2; `f_in` sampled at end of cycle 2i+2.
- Cycle 33: DONE, `done`=1, `busy`=0, final results visible. Cycle 34: IDLE; earliest new `start` accepted at cycle 34.
- Total latency start→done: 33 cycles. `abort` sampled in cycle k → `busy`=0 at k+1.

## Configuration
- `POS_SWEEP_COMPARE_EN` defined: `mismatch` register and comparator against `EXPECTED` built; updated in DONE.
- Not defined: comparator omitted, `mismatch` tied to 0; `EXPECTED` unused. All other behaviour identical.

## Test plan
- Golden evaluator, `start` pulse at cycle 0 → `done` at cycle 33 only, `truth_table`=16'h2EAC, `maxterm_count`=8, `mismatch`=0.
- Evaluator replaced by constant 1 → `truth_table`=16'hFFFF, `maxterm_count`=0, `mismatch`=1 (0 with macro undefined).
- Golden evaluator, `abort` at cycle 10 (SAMPLE index 4) → `busy`=0 at cycle 11, no `done`, `truth_table`=16'h000C, `maxterm_count`=2.
- `rst_n`=0 at cycle 20 mid-sweep → next cycle all outputs zero, state IDLE; fresh `start` then completes normally 33 cycles later.
- `start` held high continuously → sweeps accepted at cycles 0, 34, 68; `done` at 33, 67; `start` during busy/DONE ignored.
- Constant-0 evaluator → `truth_table`=16'h0000, `maxterm_count`=16 (no 5-bit overflow).
